// File: rtl/spi_txn_if.sv
// ---------------------------------------------------------------------------
// spi_txn_if
// Bundles the SPI pins and the requester/downstream handshake of the
// spi_txn_ctrl slave transaction controller.
//
// Parameters:
//   WIDTH  bits per SPI frame
//   NREQ   number of reply requesters
//
// Signals:
//   sclk, cs, mosi  SPI clock (mode 0), chip select (active low), data in
//   miso            SPI data out
//   req             per-requester reply-pending flags (level)
//   tx_data         reply words, requester i at [i*WIDTH +: WIDTH]
//   tx_ack          one-cycle pulse to the requester whose word was sent
//   rx_data         last correctly framed received word
//   rx_valid        one-cycle pulse when rx_data updates
//   frame_err       one-cycle pulse on an aborted or overlong frame
//   busy            controller is inside a transaction
//
// Modports:
//   slave   the controller side
//   master  the SPI master / requester / downstream side
// ---------------------------------------------------------------------------
interface spi_txn_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
);
    logic                    sclk;
    logic                    cs;
    logic                    mosi;
    logic                    miso;
    logic [NREQ-1:0]         req;
    logic [NREQ*WIDTH-1:0]   tx_data;
    logic [NREQ-1:0]         tx_ack;
    logic [WIDTH-1:0]        rx_data;
    logic                    rx_valid;
    logic                    frame_err;
    logic                    busy;

    modport slave (
        input  sclk, cs, mosi, req, tx_data,
        output miso, tx_ack, rx_data, rx_valid, frame_err, busy
    );

    modport master (
        output sclk, cs, mosi, req, tx_data,
        input  miso, tx_ack, rx_data, rx_valid, frame_err, busy
    );
endinterface

// File: rtl/spi_txn_ctrl.sv
// ---------------------------------------------------------------------------
// spi_txn_ctrl
// SPI slave transaction controller running entirely in the clk domain.
// sclk, cs and mosi are oversampled through 2-FF synchronizers; frames of
// WIDTH bits (MSB first, SPI mode 0) are received and delivered downstream
// with a one-cycle rx_valid pulse. The single reply slot of each frame is
// shared between NREQ requesters by round-robin arbitration.
//
// Ports:
//   clk    system clock, all logic on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    spi_txn_if.slave (SPI pins, requester and downstream handshake)
//
// Parameters:
//   WIDTH      bits per frame
//   NREQ       number of requesters (>= 2)
//   IDLE_WORD  reply shifted out when nobody is requesting
//
// Build option:
//   SPI_ECHO_EN  when defined, an un-requested frame replies with the
//                complement of the last good received word instead of
//                IDLE_WORD.
//
// Master timing contract: sclk <= clk/8 and at least 4 clk between cs fall
// and the first sclk rise.
// ---------------------------------------------------------------------------
module spi_txn_ctrl #(
    parameter int               WIDTH     = 16,
    parameter int               NREQ      = 4,
    parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
    input logic       clk,
    input logic       rst_n,
    spi_txn_if.slave  bus
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    // bit_cnt must be able to hold WIDTH+1 to flag overlong frames.
    localparam int CNT_W = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Synchronizer and edge-detect stages
    logic sclk_s1, sclk_s2, sclk_d;
    logic cs_s1,   cs_s2,   cs_d;
    logic mosi_s1, mosi_s2;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    // Datapath state
    logic [WIDTH-1:0] tx_shift_q;
    logic [WIDTH-1:0] rx_shift_q;
    logic [WIDTH-1:0] rx_data_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] grant_q;
    logic             grant_vld_q;
    logic [NREQ-1:0]  tx_ack_q;
    logic             rx_valid_q;
    logic             frame_err_q;

    // Arbiter result
    logic [PTR_W-1:0] grant_idx;
    logic             grant_hit;
    logic [WIDTH-1:0] idle_reply;

    // -----------------------------------------------------------------------
    // Input synchronizers. All stages reset to 0, so a cs that is already
    // low when reset releases never looks like a falling edge and a frame
    // in progress is ignored until cs next falls.
    // -----------------------------------------------------------------------
    // NOTE: every clocked register uses non-blocking assignment so that all
    // stages sample the pre-edge values and the synchronizer chain shifts
    // by exactly one stage per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_d  <= 1'b0;
            cs_s1   <= 1'b0;
            cs_s2   <= 1'b0;
            cs_d    <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= bus.sclk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            cs_s1   <= bus.cs;
            cs_s2   <= cs_s1;
            cs_d    <= cs_s2;
            mosi_s1 <= bus.mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    // mosi_s2 has the same depth as sclk_s2, so it is aligned with the
    // detected sclk rise.
    assign sclk_rise =  sclk_s2 & ~sclk_d;
    assign sclk_fall = ~sclk_s2 &  sclk_d;
    assign cs_rise   =  cs_s2   & ~cs_d;
    assign cs_fall   = ~cs_s2   &  cs_d;

    // -----------------------------------------------------------------------
    // Round-robin arbiter: first pending requester at or after rr_ptr.
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default at the
    // top of the block, so no path leaves it unassigned and no latch forms.
    always_comb begin
        int idx_i;
        grant_hit = 1'b0;
        grant_idx = '0;
        idx_i     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_i = int'(rr_ptr_q) + k;
            if (idx_i >= NREQ) begin
                idx_i = idx_i - NREQ;
            end
            if (!grant_hit && bus.req[PTR_W'(idx_i)]) begin
                grant_hit = 1'b1;
                grant_idx = PTR_W'(idx_i);
            end
        end
    end

`ifdef SPI_ECHO_EN
    assign idle_reply = ~rx_data_q;
`else
    assign idle_reply = IDLE_WORD;
`endif

    // -----------------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            // cs rises and sclk edges outside a frame are ignored.
            IDLE:  if (cs_fall) state_d = LOAD;
            // A cs pulse too short to reach SHIFT still closes the frame,
            // and is reported as a short frame rather than being lost.
            LOAD:  state_d = cs_rise ? DONE : SHIFT;
            SHIFT: if (cs_rise) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath. An sclk edge coinciding with the cs rise is still applied
    // here because the datapath acts on SHIFT, while the state moves to
    // DONE on the same edge; DONE therefore sees the final bit count.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            bit_cnt_q   <= '0;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            grant_vld_q <= 1'b0;
            tx_ack_q    <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // Pulses are high for exactly one cycle.
            tx_ack_q    <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;

            case (state_q)
                LOAD: begin
                    // req/tx_data are sampled only here; later changes do
                    // not affect the frame in flight.
                    if (grant_hit) begin
                        tx_shift_q <= bus.tx_data[int'(grant_idx)*WIDTH +: WIDTH];
                    end else begin
                        tx_shift_q <= idle_reply;
                    end
                    grant_q     <= grant_idx;
                    grant_vld_q <= grant_hit;
                    bit_cnt_q   <= '0;
                end

                SHIFT: begin
                    if (sclk_rise) begin
                        rx_shift_q <= {rx_shift_q[WIDTH-2:0], mosi_s2};
                        // Saturate one past WIDTH: enough to tell an
                        // overlong frame from a correct one.
                        if (bit_cnt_q != CNT_W'(WIDTH + 1)) begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                    // Mode 0: the master samples on the rise, so the next
                    // bit is presented after the fall.
                    if (sclk_fall) begin
                        tx_shift_q <= {tx_shift_q[WIDTH-2:0], 1'b0};
                    end
                end

                DONE: begin
                    if (bit_cnt_q == CNT_W'(WIDTH)) begin
                        rx_data_q  <= rx_shift_q;
                        rx_valid_q <= 1'b1;
                        if (grant_vld_q) begin
                            tx_ack_q[grant_q] <= 1'b1;
                            rr_ptr_q <= (grant_q == PTR_W'(NREQ - 1))
                                        ? '0 : grant_q + PTR_W'(1);
                        end
                    end else begin
                        // Short or overlong: the granted requester is not
                        // acknowledged and wins again on the next frame.
                        frame_err_q <= 1'b1;
                    end
                end

                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.miso      = (state_q == SHIFT) ? tx_shift_q[WIDTH-1] : 1'b0;
    assign bus.tx_ack    = tx_ack_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_txn_ctrl
// Self-checking bench for spi_txn_ctrl. A table of frames (requests, reply
// words, master data, expected reply and handshake) is applied in a loop,
// followed by a hand-written reset-during-frame sequence and two
// un-requested frames whose reply depends on SPI_ECHO_EN. Received words
// are checked through a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_spi_txn_ctrl;

    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int HALF  = 8;   // clk cycles per sclk half period
    localparam logic [WIDTH-1:0] IDLE_WORD = 16'h0000;

    localparam logic [NREQ*WIDTH-1:0] TXD_RR = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    localparam logic [NREQ*WIDTH-1:0] TXD_S  = {16'h1003, 16'h1234, 16'h1001, 16'h1000};

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    spi_txn_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    spi_txn_ctrl #(
        .WIDTH     (WIDTH),
        .NREQ      (NREQ),
        .IDLE_WORD (IDLE_WORD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [NREQ-1:0]       req;
        logic [NREQ*WIDTH-1:0] txd;
        logic [31:0]           mosi;   // bits [nbits-1:0] sent MSB first
        int                    nbits;
        logic [WIDTH-1:0]      reply;  // word expected on miso
        logic                  idle;   // no requester: reply is the idle word
        logic                  good;   // frame expected to be accepted
        logic [NREQ-1:0]       ack;    // expected tx_ack pulse
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state: written only by the monitor process.
    logic [WIDTH-1:0] obs_rx [64];
    int               rx_cnt   = 0;
    int               err_cnt  = 0;
    int               ack_cnt  = 0;
    int               busy_cnt = 0;
    logic [NREQ-1:0]  last_ack = '0;

    // Scoreboard state: written only by the main process.
    logic [WIDTH-1:0] exp_q [$];
    int               rd_idx   = 0;
    logic [WIDTH-1:0] model_rx = '0;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            obs_rx[rx_cnt % 64] <= bus.rx_data;
            rx_cnt <= rx_cnt + 1;
        end
        if (bus.frame_err) err_cnt <= err_cnt + 1;
        if (bus.tx_ack != '0) begin
            ack_cnt  <= ack_cnt + 1;
            last_ack <= bus.tx_ack;
        end
        if (bus.busy) busy_cnt <= busy_cnt + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] idle_word();
`ifdef SPI_ECHO_EN
        return ~model_rx;
`else
        return IDLE_WORD;
`endif
    endfunction

    // Expected miso capture for a frame of n bits: the reply MSB first,
    // truncated for short frames and followed by zeros for long ones.
    function automatic logic [31:0] exp_bits(input logic [WIDTH-1:0] w, input int n);
        logic [31:0] x;
        x = {16'h0000, w};
        if (n <= WIDTH) return x >> (WIDTH - n);
        return x << (n - WIDTH);
    endfunction

    task automatic spi_bits(input logic [31:0] word, input int nbits, output logic [31:0] rd);
        rd = '0;
        for (int b = nbits - 1; b >= 0; b--) begin
            bus.mosi = word[b];
            repeat (HALF) @(negedge clk);
            bus.sclk = 1'b1;
            rd = {rd[30:0], bus.miso};
            repeat (HALF) @(negedge clk);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [31:0] word, input int nbits, output logic [31:0] rd);
        @(negedge clk);
        bus.cs = 1'b0;
        repeat (6) @(negedge clk);
        spi_bits(word, nbits, rd);
        repeat (HALF) @(negedge clk);
        bus.cs = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic drain();
        logic [WIDTH-1:0] e;
        while (rd_idx < rx_cnt) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard: unexpected rx word %h, none expected", obs_rx[rd_idx % 64]);
            end else begin
                e = exp_q.pop_front();
                check("scoreboard rx_data", obs_rx[rd_idx % 64], e);
            end
            rd_idx++;
        end
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        logic [31:0]      rd;
        logic [WIDTH-1:0] reply;
        int rx0, err0, ack0;
        @(negedge clk);
        bus.req     = v.req;
        bus.tx_data = v.txd;
        reply = v.idle ? idle_word() : v.reply;
        rx0  = rx_cnt;
        err0 = err_cnt;
        ack0 = ack_cnt;
        if (v.good) begin
            exp_q.push_back(v.mosi[WIDTH-1:0]);
            model_rx = v.mosi[WIDTH-1:0];
        end
        spi_frame(v.mosi, v.nbits, rd);
        check({tag, " miso"},            rd, exp_bits(reply, v.nbits));
        check({tag, " rx_valid pulses"}, rx_cnt - rx0, v.good ? 1 : 0);
        check({tag, " frame_err pulses"}, err_cnt - err0, v.good ? 0 : 1);
        check({tag, " tx_ack pulses"},   ack_cnt - ack0, (v.ack != '0) ? 1 : 0);
        if (v.ack != '0) check({tag, " tx_ack value"}, last_ack, v.ack);
        check({tag, " rx_data held"},    bus.rx_data, model_rx);
        check({tag, " busy idle"},       bus.busy, 1'b0);
        drain();
    endtask

    vec_t vecs [11];

    initial begin
        logic [31:0] rd;
        int rx0, err0, busy0;
        vec_t v;

        //            req      txd     mosi          n   reply     idle  good  ack
        vecs[0]  = '{4'b0000, TXD_RR, 32'h0000A5C3, 16, 16'h0000, 1'b1, 1'b1, 4'b0000};
        vecs[1]  = '{4'b0100, TXD_S,  32'h0000FFFF, 16, 16'h1234, 1'b0, 1'b1, 4'b0100};
        vecs[2]  = '{4'b1111, TXD_RR, 32'h00000001, 16, 16'h1003, 1'b0, 1'b1, 4'b1000};
        vecs[3]  = '{4'b1111, TXD_RR, 32'h00001357, 16, 16'h1000, 1'b0, 1'b1, 4'b0001};
        vecs[4]  = '{4'b1111, TXD_RR, 32'h00002468, 16, 16'h1001, 1'b0, 1'b1, 4'b0010};
        vecs[5]  = '{4'b1111, TXD_RR, 32'h00009ABC, 16, 16'h1002, 1'b0, 1'b1, 4'b0100};
        vecs[6]  = '{4'b1111, TXD_RR, 32'h0000DEF0, 16, 16'h1003, 1'b0, 1'b1, 4'b1000};
        vecs[7]  = '{4'b0001, TXD_RR, 32'h000001AB,  9, 16'h1000, 1'b0, 1'b0, 4'b0000};
        vecs[8]  = '{4'b0001, TXD_RR, 32'h00004321, 16, 16'h1000, 1'b0, 1'b1, 4'b0001};
        vecs[9]  = '{4'b0010, TXD_RR, 32'h00015555, 17, 16'h1001, 1'b0, 1'b0, 4'b0000};
        vecs[10] = '{4'b1111, TXD_RR, 32'h00000F0F, 16, 16'h1001, 1'b0, 1'b1, 4'b0010};

        rst_n       = 1'b0;
        bus.cs      = 1'b1;
        bus.sclk    = 1'b0;
        bus.mosi    = 1'b0;
        bus.req     = '0;
        bus.tx_data = '0;

        repeat (4) @(negedge clk);
        check("reset miso",      bus.miso,      1'b0);
        check("reset tx_ack",    bus.tx_ack,    4'b0000);
        check("reset rx_data",   bus.rx_data,   16'h0000);
        check("reset rx_valid",  bus.rx_valid,  1'b0);
        check("reset frame_err", bus.frame_err, 1'b0);
        check("reset busy",      bus.busy,      1'b0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset pulsed in the middle of a frame with cs held low.
        @(negedge clk);
        bus.req     = 4'b0100;
        bus.tx_data = TXD_RR;
        bus.cs      = 1'b0;
        repeat (6) @(negedge clk);
        spi_bits(32'h000000AA, 8, rd);
        check("pre-reset busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_rx = '0;
        @(negedge clk);
        check("mid-reset miso",      bus.miso,      1'b0);
        check("mid-reset tx_ack",    bus.tx_ack,    4'b0000);
        check("mid-reset rx_data",   bus.rx_data,   16'h0000);
        check("mid-reset rx_valid",  bus.rx_valid,  1'b0);
        check("mid-reset frame_err", bus.frame_err, 1'b0);
        check("mid-reset busy",      bus.busy,      1'b0);
        rx0   = rx_cnt;
        err0  = err_cnt;
        busy0 = busy_cnt;
        spi_bits(32'h00000055, 8, rd);
        repeat (HALF) @(negedge clk);
        bus.cs = 1'b1;
        repeat (10) @(negedge clk);
        check("abandoned frame busy cycles", busy_cnt - busy0, 0);
        check("abandoned frame rx_valid",    rx_cnt - rx0, 0);
        check("abandoned frame frame_err",   err_cnt - err0, 0);

        // Pointer restarts at 0 after reset.
        v = '{4'b1111, TXD_RR, 32'h0000C0DE, 16, 16'h1000, 1'b0, 1'b1, 4'b0001};
        apply_vec(v, "post-reset");

        // Two un-requested frames: idle word, or echo of ~last word.
        v = '{4'b0000, TXD_RR, 32'h000000FF, 16, 16'h0000, 1'b1, 1'b1, 4'b0000};
        apply_vec(v, "idle1");
        v = '{4'b0000, TXD_RR, 32'h00003C3C, 16, 16'h0000, 1'b1, 1'b1, 4'b0000};
        apply_vec(v, "idle2");

        check("scoreboard empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
